// File: rtl/mole_game_pkg.sv
// Shared types and constants for the whack-a-mole game sequencer.
package mole_game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_UP   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Non-zero seed keeps the LFSR out of its lock-up state.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Taps for x^8 + x^6 + x^5 + x^4 + 1 (bits 7, 5, 4, 3).
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Width needed for a tick timer holding the larger of the two windows.
  function automatic int unsigned timer_width(input int unsigned up_ticks,
                                              input int unsigned gap_ticks);
    int unsigned max_ticks;
    max_ticks = (up_ticks > gap_ticks) ? up_ticks : gap_ticks;
    return (max_ticks < 2) ? 1 : $clog2(max_ticks + 1);
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// 8-bit Fibonacci LFSR used to pick the next mole; steps every clock.
module mole_lfsr
  import mole_game_pkg::*;
#(
  parameter int unsigned OUT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  output logic [OUT_W-1:0] rnd
);

  logic [7:0] lfsr_q;

  // Shift left, feeding back the XOR of the tap bits; reseed on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  assign rnd = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game sequencer: runs NUM_ROUNDS mole pop-ups, judges button
// presses and flags hits/misses for the score counter.
// Optional build macro SPEEDUP_EN: shrink the mole window as rounds advance.
module mole_game_ctrl
  import mole_game_pkg::*;
#(
  parameter int unsigned NUM_MOLES  = 4,
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned UP_TICKS   = 750,
  parameter int unsigned GAP_TICKS  = 250,
  parameter int unsigned NUM_ROUNDS = 30
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_MOLES-1:0] btn,
  output logic [NUM_MOLES-1:0] mole,
  output logic                 hit,
  output logic                 miss,
  output logic                 enable_score,
  output logic                 game_over,
  output logic [7:0]           round
);

  localparam int unsigned SEL_W = $clog2(NUM_MOLES);
  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TMR_W = timer_width(UP_TICKS, GAP_TICKS);

  state_t               state_q, state_n;
  logic [PRE_W-1:0]     pre_q;
  logic                 tick;
  logic [TMR_W-1:0]     timer_q, timer_n, window;
  logic                 expire;
  logic [NUM_MOLES-1:0] mole_q, mole_n;
  logic                 hit_q, hit_n, miss_q, miss_n;
  logic [7:0]           round_q, round_n, round_inc;
  logic [SEL_W-1:0]     rnd, sel, prev_q, prev_n;
  logic                 prev_valid_q, prev_valid_n;

  mole_lfsr #(.OUT_W(SEL_W)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .rnd   (rnd)
  );

  // Free-running prescaler producing one tick every TICK_DIV clocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     pre_q <= '0;
    else if (tick) pre_q <= '0;
    else           pre_q <= pre_q + 1'b1;
  end

  assign tick = (pre_q == PRE_W'(TICK_DIV - 1));

  // Expiry is the tick that takes the timer to zero, so every state
  // entered on expiry starts phase-aligned with the prescaler.
  assign expire    = tick && (timer_q <= TMR_W'(1));
  assign round_inc = round_q + 8'd1;

  // Bump the pick by one (wrapping) to avoid repeating the previous mole.
  assign sel = (prev_valid_q && (rnd == prev_q)) ? rnd + 1'b1 : rnd;

`ifdef SPEEDUP_EN
  logic [31:0] speed_cut;
  assign speed_cut = 32'(round_inc[7:3]) * (UP_TICKS / 8);
  assign window = (speed_cut + (UP_TICKS / 4) >= UP_TICKS) ?
                  TMR_W'(UP_TICKS / 4) : TMR_W'(UP_TICKS - speed_cut);
`else
  assign window = TMR_W'(UP_TICKS);
`endif

  // Next-state and next-output logic for the game sequence.
  always_comb begin
    state_n      = state_q;
    timer_n      = (tick && (timer_q != '0)) ? timer_q - 1'b1 : timer_q;
    mole_n       = mole_q;
    round_n      = round_q;
    hit_n        = 1'b0;
    miss_n       = 1'b0;
    prev_n       = prev_q;
    prev_valid_n = prev_valid_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        mole_n = '0;
        if (start) begin
          state_n      = ST_GAP;
          timer_n      = TMR_W'(GAP_TICKS);
          round_n      = '0;
          prev_valid_n = 1'b0;
        end
      end
      ST_GAP: begin
        mole_n = '0;
        if (expire) begin
          if (round_q == 8'(NUM_ROUNDS)) begin
            state_n = ST_DONE;
          end else begin
            state_n      = ST_UP;
            mole_n[sel]  = 1'b1;
            round_n      = round_inc;
            timer_n      = window;
            prev_n       = sel;
            prev_valid_n = 1'b1;
          end
        end
      end
      ST_UP: begin
        if ((btn & mole_q) != '0) begin
          hit_n   = 1'b1;
          mole_n  = '0;
          state_n = ST_GAP;
          timer_n = TMR_W'(GAP_TICKS);
        end else if (expire) begin
          miss_n  = 1'b1;
          mole_n  = '0;
          state_n = ST_GAP;
          timer_n = TMR_W'(GAP_TICKS);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset returns straight to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      mole_q       <= '0;
      round_q      <= '0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
    end else begin
      state_q      <= state_n;
      timer_q      <= timer_n;
      mole_q       <= mole_n;
      round_q      <= round_n;
      hit_q        <= hit_n;
      miss_q       <= miss_n;
      prev_q       <= prev_n;
      prev_valid_q <= prev_valid_n;
    end
  end

  assign mole         = mole_q;
  assign hit          = hit_q;
  assign miss         = miss_q;
  assign round        = round_q;
  assign enable_score = (state_q == ST_GAP) || (state_q == ST_UP);
  assign game_over    = (state_q == ST_DONE);

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Randomized self-checking bench for mole_game_ctrl with a deadline-based
// reference model of the game.
module tb_mole_game_ctrl;

  localparam int NM  = 4;
  localparam int TD  = 4;
  localparam int GAP = 2;
`ifdef SPEEDUP_EN
  localparam int UP  = 64;
  localparam int NR  = 20;
`else
  localparam int UP  = 8;
  localparam int NR  = 3;
`endif
  localparam int LIMIT = NR * (UP + GAP) * TD + 8 * TD + 50;

  logic          clk;
  logic          reset, start;
  logic [NM-1:0] btn;
  logic [NM-1:0] mole;
  logic          hit, miss, enable_score, game_over;
  logic [7:0]    round;

  mole_game_ctrl #(
    .NUM_MOLES  (NM),
    .TICK_DIV   (TD),
    .UP_TICKS   (UP),
    .GAP_TICKS  (GAP),
    .NUM_ROUNDS (NR)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .btn          (btn),
    .mole         (mole),
    .hit          (hit),
    .miss         (miss),
    .enable_score (enable_score),
    .game_over    (game_over),
    .round        (round)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {PH_IDLE, PH_GAP, PH_UP, PH_DONE} phase_t;

  int unsigned n_cmp, n_bad;
  int          k;                 // clock edges since reset release
  logic [7:0]  m_lfsr;
  phase_t      m_phase;
  int          m_round, m_idx, m_prev, m_deadline, m_rise;
  bit          m_prev_ok;
  bit          e_hit, e_miss;
  int          cur_mode, plan, plan_delay;
  int          g_hits_o, g_miss_o, g_hits_m, g_miss_m;
  logic [NM-1:0] obs_last_mole, obs_prev_mole;
  bit          obs_prev_ok;
  int          obs_rise;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, k);
    end
  endtask

  function automatic int win_ticks(input int r);
    int w;
    w = UP;
`ifdef SPEEDUP_EN
    w = UP - (r / 8) * (UP / 8);
    if (w < UP / 4) w = UP / 4;
`endif
    return w;
  endfunction

  // Edge at which the n-th tick after edge k0 lands (ticks on k % TD == TD-1).
  function automatic int nth_tick(input int k0, input int n);
    int first;
    first = k0 + 1 + (TD - 1 - ((k0 + 1) % TD));
    return first + (n - 1) * TD;
  endfunction

  task automatic model_reset();
    k = 0; m_lfsr = 8'hA5; m_phase = PH_IDLE; m_round = 0;
    m_prev_ok = 0; e_hit = 0; e_miss = 0; plan = 0;
    obs_last_mole = '0; obs_prev_ok = 0;
  endtask

  task automatic model_edge(input logic st, input logic [NM-1:0] b);
    int s;
    e_hit = 0; e_miss = 0;
    case (m_phase)
      PH_IDLE, PH_DONE:
        if (st) begin
          m_phase = PH_GAP; m_round = 0; m_prev_ok = 0;
          m_deadline = nth_tick(k, GAP);
        end
      PH_GAP:
        if (k == m_deadline) begin
          if (m_round == NR) m_phase = PH_DONE;
          else begin
            s = int'(m_lfsr) % NM;
            if (m_prev_ok && s == m_prev) s = (s + 1) % NM;
            m_idx = s; m_prev = s; m_prev_ok = 1;
            m_round++;
            m_deadline = nth_tick(k, win_ticks(m_round));
            m_rise = k; m_phase = PH_UP;
          end
        end
      PH_UP:
        if (b[m_idx]) begin
          e_hit = 1; m_phase = PH_GAP; m_deadline = nth_tick(k, GAP);
        end else if (k == m_deadline) begin
          e_miss = 1; m_phase = PH_GAP; m_deadline = nth_tick(k, GAP);
        end
      default: ;
    endcase
  endtask

  function automatic logic [NM-1:0] pick_btn(input int mode);
    logic [NM-1:0] b, r, onehot;
    b = '0; r = NM'($urandom); onehot = '0;
    if (m_phase == PH_UP) begin
      onehot[m_idx] = 1'b1;
      case (plan)
        1: if (k == m_rise + plan_delay) b = onehot;
        2: if (k == m_deadline) b = onehot;
        3: if ($urandom_range(0, 2) == 0) b = r & ~onehot;
        default: ;
      endcase
    end else if (m_phase == PH_GAP && mode != 0 && $urandom_range(0, 2) == 0) begin
      b = r;
    end
    return b;
  endfunction

  task automatic run_cycle(input logic st, input logic [NM-1:0] b);
    logic [NM-1:0] em;
    start = st; btn = b;
    model_edge(st, b);
    @(posedge clk); #1;
    em = '0;
    if (m_phase == PH_UP) em[m_idx] = 1'b1;
    check("mole", mole, em);
    check("hit", hit, e_hit);
    check("miss", miss, e_miss);
    check("enable_score", enable_score, (m_phase == PH_GAP || m_phase == PH_UP));
    check("game_over", game_over, m_phase == PH_DONE);
    check("round", round, m_round);
    g_hits_o += int'(hit); g_miss_o += int'(miss);
    g_hits_m += int'(e_hit); g_miss_m += int'(e_miss);
    if (mole != '0 && obs_last_mole == '0) begin
      if (obs_prev_ok) check("no_repeat", mole != obs_prev_mole, 1);
      obs_prev_mole = mole; obs_prev_ok = 1; obs_rise = k;
    end
    if (hit === 1'b1 && (plan == 1 || plan == 2))
      check("hit_timing", k - obs_rise, (plan == 1) ? plan_delay : win_ticks(m_round) * TD);
    if (miss === 1'b1)
      check("miss_timing", k - obs_rise, win_ticks(m_round) * TD);
    obs_last_mole = mole;
    if (m_phase == PH_UP && m_rise == k) begin
      case (cur_mode)
        0:       plan = 0;
        3:       begin plan = 1; plan_delay = 5; end
        default: begin
          plan = $urandom_range(0, 3);
          plan_delay = $urandom_range(1, win_ticks(m_round) * TD - 1);
        end
      endcase
    end
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    k++;
    @(negedge clk);
    start = 1'b0; btn = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mole"}, mole, 0);
    check({tag, "_hit"}, hit, 0);
    check({tag, "_miss"}, miss, 0);
    check({tag, "_enable"}, enable_score, 0);
    check({tag, "_game_over"}, game_over, 0);
    check({tag, "_round"}, round, 0);
  endtask

  task automatic play_game(input int mode);
    int guard;
    cur_mode = mode; plan = 0;
    g_hits_o = 0; g_miss_o = 0; g_hits_m = 0; g_miss_m = 0;
    obs_prev_ok = 0;
    run_cycle(1'b1, '0);
    check("round_after_start", round, 0);
    check("enable_after_start", enable_score, 1);
    guard = 0;
    while (m_phase != PH_DONE && guard < LIMIT) begin
      run_cycle((mode == 2) && ($urandom_range(0, 15) == 0), pick_btn(mode));
      guard++;
    end
    if (guard >= LIMIT) check("game_bound", 0, 1);
    run_cycle(1'b0, NM'($urandom));
    run_cycle(1'b0, '0);
    check("end_game_over", game_over, 1);
    check("end_enable", enable_score, 0);
    check("end_round", round, NR);
    check("end_hits", g_hits_o, g_hits_m);
    check("end_misses", g_miss_o, g_miss_m);
    if (mode == 0) begin
      check("idle_game_hits", g_hits_o, 0);
      check("idle_game_misses", g_miss_o, NR);
    end
  endtask

  initial begin
    int guard;
    n_cmp = 0; n_bad = 0;
    reset = 1'b1; start = 1'b0; btn = '0;
    cur_mode = 0; plan = 0; plan_delay = 0; obs_rise = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    model_reset();
    repeat (5) run_cycle(1'b0, '0);

    play_game(0);
    play_game(3);
    for (int g = 0; g < 4; g++) play_game(1 + (g % 2));

    // Reset in the middle of a mole window.
    cur_mode = 0; plan = 0; obs_prev_ok = 0;
    run_cycle(1'b1, '0);
    guard = 0;
    while (!(m_phase == PH_UP && k >= m_rise + 3) && guard < LIMIT) begin
      run_cycle(1'b0, '0);
      guard++;
    end
    if (guard >= LIMIT) check("reset_setup_bound", 0, 1);
    reset = 1'b1;
    #1;
    check_all_zero("midgame_reset");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (3) run_cycle(1'b0, '0);
    play_game(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
